// File: rtl/tl45_regfile_sb_if.sv
// Register-file bundle between writeback, decode/operand-fetch and the regfile.
// master = pipeline side driving writes/reads/issues, slave = tl45_regfile_sb.
interface tl45_regfile_sb_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
);
  logic              i_rf_en;
  logic [IDX_W-1:0]  i_rf_reg;
  logic [DATA_W-1:0] i_rf_val;
  logic              i_rd_stall;
  logic [IDX_W-1:0]  i_sr1;
  logic [IDX_W-1:0]  i_sr2;
  logic [DATA_W-1:0] o_sr1_val;
  logic [DATA_W-1:0] o_sr2_val;
  logic              i_issue;
  logic [IDX_W-1:0]  i_issue_dr;
  logic              i_flush;
  logic              o_hazard;
  logic              o_issue_stall;

  modport master (
    output i_rf_en, i_rf_reg, i_rf_val, i_rd_stall, i_sr1, i_sr2,
    output i_issue, i_issue_dr, i_flush,
    input  o_sr1_val, o_sr2_val, o_hazard, o_issue_stall
  );

  modport slave (
    input  i_rf_en, i_rf_reg, i_rf_val, i_rd_stall, i_sr1, i_sr2,
    input  i_issue, i_issue_dr, i_flush,
    output o_sr1_val, o_sr2_val, o_hazard, o_issue_stall
  );
endinterface

// File: rtl/tl45_regfile_sb.sv
// 16x32 register file with 1-cycle registered reads and a per-register pending-write scoreboard.
// Optional macro TL45_REGFILE_BYPASS_EN adds write-to-read forwarding and same-cycle hazard release.
module tl45_regfile_sb #(
  parameter int NREGS  = 16,
  parameter int PEND_W = 2,
  parameter int DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  tl45_regfile_sb_if.slave   rf
);
  localparam int IDX_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs    [NREGS];
  logic [PEND_W-1:0] cnt     [NREGS];
  logic [PEND_W-1:0] cnt_nxt [NREGS];

  logic [DATA_W-1:0] sr1_val_p1, sr2_val_p1;
  logic [DATA_W-1:0] rd1_p0, rd2_p0;
  logic              inc, dec, issue_stall;
  logic              pend1, pend2, retire1, retire2;

  function automatic logic cnt_full(input logic [PEND_W-1:0] c);
    return c == {PEND_W{1'b1}};
  endfunction

  assign issue_stall = rf.i_issue && (rf.i_issue_dr != '0) && cnt_full(cnt[rf.i_issue_dr]);
  assign inc         = rf.i_issue && (rf.i_issue_dr != '0) && !issue_stall;
  assign dec         = rf.i_rf_en && (rf.i_rf_reg != '0) && (cnt[rf.i_rf_reg] != '0);

`ifdef TL45_REGFILE_BYPASS_EN
  // A last outstanding write retiring this cycle is forwarded, so it no longer blocks decode.
  assign retire1 = rf.i_rf_en && (rf.i_rf_reg == rf.i_sr1) && (cnt[rf.i_sr1] == PEND_W'(1));
  assign retire2 = rf.i_rf_en && (rf.i_rf_reg == rf.i_sr2) && (cnt[rf.i_sr2] == PEND_W'(1));
`else
  assign retire1 = 1'b0;
  assign retire2 = 1'b0;
`endif

  assign pend1 = (rf.i_sr1 != '0) && (cnt[rf.i_sr1] != '0) && !retire1;
  assign pend2 = (rf.i_sr2 != '0) && (cnt[rf.i_sr2] != '0) && !retire2;

  assign rf.o_hazard      = pend1 || pend2;
  assign rf.o_issue_stall = issue_stall;
  assign rf.o_sr1_val     = sr1_val_p1;
  assign rf.o_sr2_val     = sr2_val_p1;

  // Stage p0: read-port selection (architectural value, optionally forwarded write data)
  always_comb begin
    rd1_p0 = (rf.i_sr1 == '0) ? '0 : regs[rf.i_sr1];
    rd2_p0 = (rf.i_sr2 == '0) ? '0 : regs[rf.i_sr2];
`ifdef TL45_REGFILE_BYPASS_EN
    if (rf.i_rf_en && (rf.i_sr1 != '0) && (rf.i_rf_reg == rf.i_sr1)) rd1_p0 = rf.i_rf_val;
    if (rf.i_rf_en && (rf.i_sr2 != '0) && (rf.i_rf_reg == rf.i_sr2)) rd2_p0 = rf.i_rf_val;
`endif
  end

  // Matching inc and dec on one register cancel; flush overrides both.
  always_comb begin
    for (int r = 0; r < NREGS; r++) cnt_nxt[r] = cnt[r];
    cnt_nxt[0] = '0;
    if (rf.i_flush) begin
      for (int r = 0; r < NREGS; r++) cnt_nxt[r] = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if ((inc && (rf.i_issue_dr == IDX_W'(r))) && !(dec && (rf.i_rf_reg == IDX_W'(r))))
          cnt_nxt[r] = cnt[r] + PEND_W'(1);
        else if ((dec && (rf.i_rf_reg == IDX_W'(r))) && !(inc && (rf.i_issue_dr == IDX_W'(r))))
          cnt_nxt[r] = cnt[r] - PEND_W'(1);
      end
    end
  end

  // Stage p1: register array, scoreboard and read outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sr1_val_p1 <= '0;
      sr2_val_p1 <= '0;
    end else begin
      if (rf.i_rf_en && (rf.i_rf_reg != '0)) regs[rf.i_rf_reg] <= rf.i_rf_val;
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
      if (!rf.i_rd_stall) begin
        sr1_val_p1 <= rd1_p0;
        sr2_val_p1 <= rd2_p0;
      end
    end
  end
endmodule

// File: tb/tb_tl45_regfile_sb.sv
// Directed bench for tl45_regfile_sb: expected read data is queued at drive time and
// popped one cycle later; hazard/stall are checked combinationally.
module tb_tl45_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] v1;
    logic [31:0] v2;
  } rd_exp_t;
  rd_exp_t exp_q[$];

`ifdef TL45_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  tl45_regfile_sb_if bus ();

  tl45_regfile_sb dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .rf        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input string tag, input logic [31:0] v1, input logic [31:0] v2);
    rd_exp_t e;
    e.tag = tag;
    e.v1  = v1;
    e.v2  = v2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_sr1"}, bus.o_sr1_val, e.v1);
      check({e.tag, "_sr2"}, bus.o_sr2_val, e.v2);
    end
  endtask

  task automatic idle();
    bus.i_rf_en = 0; bus.i_rf_reg = 0; bus.i_rf_val = 0; bus.i_rd_stall = 0;
    bus.i_issue = 0; bus.i_issue_dr = 0; bus.i_flush = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    bus.i_sr1 = 0; bus.i_sr2 = 0;
    // reset wins over a concurrent write and issue
    bus.i_rf_en = 1; bus.i_rf_reg = 3; bus.i_rf_val = 32'h1111_1111;
    bus.i_issue = 1; bus.i_issue_dr = 3;
    tick(); tick();
    idle();
    #1;
    check("rst_sr1", bus.o_sr1_val, 32'h0);
    check("rst_sr2", bus.o_sr2_val, 32'h0);
    rst_n = 1;
    bus.i_sr1 = 3; bus.i_sr2 = 0;
    #1;
    check("rst_hazard", bus.o_hazard, 1'b0);
    check("rst_stall", bus.o_issue_stall, 1'b0);
    expect_read("rst_read", 32'h0, 32'h0);
    tick();

    // write r5 then read it; r0 write dropped
    bus.i_rf_en = 1; bus.i_rf_reg = 5; bus.i_rf_val = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.i_sr1 = 5; bus.i_sr2 = 0;
    expect_read("rd_r5", 32'hDEAD_BEEF, 32'h0);
    tick();
    bus.i_rf_en = 1; bus.i_rf_reg = 0; bus.i_rf_val = 32'h0000_1234;
    tick();
    idle();
    bus.i_sr1 = 0; bus.i_sr2 = 5;
    expect_read("rd_r0", 32'h0, 32'hDEAD_BEEF);
    tick();

    // same-cycle write/read of r9: forwarded only with bypass
    bus.i_rf_en = 1; bus.i_rf_reg = 9; bus.i_rf_val = 32'hA5A5_A5A5;
    bus.i_sr1 = 9; bus.i_sr2 = 5;
    expect_read("byp_r9", BYP ? 32'hA5A5_A5A5 : 32'h0, 32'hDEAD_BEEF);
    tick();
    idle();
    expect_read("rd_r9", 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    tick();
    // read stall holds outputs
    bus.i_rd_stall = 1; bus.i_sr1 = 5; bus.i_sr2 = 9;
    expect_read("rd_hold", 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    tick();
    idle();

    // scoreboard saturation on r7
    bus.i_sr1 = 0; bus.i_sr2 = 0;
    bus.i_issue = 1; bus.i_issue_dr = 7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("sat_nostall%0d", k), bus.o_issue_stall, 1'b0);
      tick();
    end
    #1;
    check("sat_stall", bus.o_issue_stall, 1'b1);
    tick();
    idle();
    bus.i_sr2 = 7;
    #1;
    check("sat_hazard", bus.o_hazard, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.i_rf_en = 1; bus.i_rf_reg = 7; bus.i_rf_val = 32'h70 + k;
      #1;
      check($sformatf("ret_same%0d", k), bus.o_hazard, (k == 2 && BYP) ? 1'b0 : 1'b1);
      tick();
    end
    idle();
    #1;
    check("ret_clear", bus.o_hazard, 1'b0);
    bus.i_sr1 = 7; bus.i_sr2 = 0;
    expect_read("rd_r7", 32'h72, 32'h0);
    tick();

    // stalled issue with same-cycle retire still does not increment (r3 ends at 2)
    bus.i_issue = 1; bus.i_issue_dr = 3;
    tick(); tick(); tick();
    bus.i_rf_en = 1; bus.i_rf_reg = 3; bus.i_rf_val = 32'h33;
    #1;
    check("stall_retire", bus.o_issue_stall, 1'b1);
    tick();
    idle();
    bus.i_rf_en = 1; bus.i_rf_reg = 3; bus.i_rf_val = 32'h34;
    tick();
    idle();
    bus.i_sr1 = 3;
    #1;
    check("stall_left1", bus.o_hazard, 1'b1);
    bus.i_rf_en = 1; bus.i_rf_reg = 3; bus.i_rf_val = 32'h35;
    tick();
    idle();
    #1;
    check("stall_left0", bus.o_hazard, 1'b0);

    // simultaneous issue and retire on r4
    bus.i_issue = 1; bus.i_issue_dr = 4;
    tick();
    bus.i_rf_en = 1; bus.i_rf_reg = 4; bus.i_rf_val = 32'h44;
    bus.i_sr1 = 4;
    #1;
    check("sim_same", bus.o_hazard, BYP ? 1'b0 : 1'b1);
    tick();
    idle();
    #1;
    check("sim_after", bus.o_hazard, 1'b1);
    bus.i_issue = 1; bus.i_issue_dr = 0;
    #1;
    check("r0_nostall", bus.o_issue_stall, 1'b0);
    idle();
    bus.i_rf_en = 1; bus.i_rf_reg = 4; bus.i_rf_val = 32'h45;
    tick();
    idle();
    #1;
    check("sim_clear", bus.o_hazard, 1'b0);

    // flush with concurrent write, then no underflow
    bus.i_issue = 1; bus.i_issue_dr = 2;
    tick(); tick();
    idle();
    bus.i_sr1 = 2;
    #1;
    check("fl_pend", bus.o_hazard, 1'b1);
    bus.i_flush = 1; bus.i_rf_en = 1; bus.i_rf_reg = 2; bus.i_rf_val = 32'h55;
    tick();
    idle();
    #1;
    check("fl_clear", bus.o_hazard, 1'b0);
    bus.i_sr2 = 2;
    expect_read("fl_data", 32'h55, 32'h55);
    tick();
    bus.i_rf_en = 1; bus.i_rf_reg = 2; bus.i_rf_val = 32'h66;
    tick();
    idle();
    #1;
    check("uf_hazard", bus.o_hazard, 1'b0);
    bus.i_issue = 1; bus.i_issue_dr = 2;
    #1;
    check("uf_stall", bus.o_issue_stall, 1'b0);
    tick();
    idle();
    #1;
    check("uf_one", bus.o_hazard, 1'b1);
    bus.i_rf_en = 1; bus.i_rf_reg = 2; bus.i_rf_val = 32'h67;
    tick();
    idle();
    #1;
    check("uf_done", bus.o_hazard, 1'b0);

    // reset mid-sequence clears data, counters and outputs
    bus.i_issue = 1; bus.i_issue_dr = 6;
    tick();
    rst_n = 0;
    bus.i_rf_en = 1; bus.i_rf_reg = 5; bus.i_rf_val = 32'hFFFF_FFFF;
    tick();
    rst_n = 1;
    idle();
    bus.i_sr1 = 5; bus.i_sr2 = 6;
    #1;
    check("mrst_out", bus.o_sr1_val, 32'h0);
    check("mrst_hazard", bus.o_hazard, 1'b0);
    expect_read("mrst_read", 32'h0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
